// File: rtl/str_skid_receiver.sv
// str_skid_receiver: receive end of the registered data link.
// Two-entry skid buffer between a valid/ready sender and a consumer, with a
// saturating count of accepted words.
// Optional feature macro: STR_RX_PARITY_EN adds the in_par input and the
// sticky par_err output (even parity over in_data).
//
// state | meaning
// EMPTY | no word held; out_valid=0
// ONE   | out_reg holds the only word
// TWO   | out_reg holds the oldest word, skid_reg the next; in_ready=0
module str_skid_receiver #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
`ifdef STR_RX_PARITY_EN
    input  logic              in_par,
`endif
    input  logic              out_ready,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
`ifdef STR_RX_PARITY_EN
    output logic              par_err,
`endif
    output logic [CNT_W-1:0]  rx_count
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t            state;
    logic [DATA_W-1:0] out_reg;
    logic [DATA_W-1:0] skid_reg;
    logic              accept;
    logic              pop;

    // Ready depends only on buffer occupancy (and reset), never on in_valid
    // or out_ready, so the sender sees a clean registered-style decode.
    assign in_ready  = (state != TWO) && !rst;
    assign out_valid = (state != EMPTY);
    assign out_data  = out_reg;
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Buffer occupancy FSM; a reset drops whatever words are held.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            out_reg  <= '0;
            skid_reg <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state   <= ONE;
                        out_reg <= in_data;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        out_reg <= in_data;
                    end else if (accept) begin
                        state    <= TWO;
                        skid_reg <= in_data;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state   <= ONE;
                        out_reg <= skid_reg;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

    // Accepted-word counter, holds at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_count <= '0;
        end else if (accept && (rx_count != {CNT_W{1'b1}})) begin
            rx_count <= rx_count + CNT_W'(1);
        end
    end

`ifdef STR_RX_PARITY_EN
    // Sticky parity flag; the offending word is still buffered and counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err <= 1'b0;
        end else if (accept && (in_par != ^in_data)) begin
            par_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_str_skid_receiver.sv
// Directed bench for str_skid_receiver: reset release, streaming, stall with
// held word, mid-operation reset, counter saturation (CNT_W=4 instance) and,
// when STR_RX_PARITY_EN is defined, the sticky parity flag.
module tb_str_skid_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       in_ready,  in_ready_s;
    logic       out_valid, out_valid_s;
    logic [7:0] out_data,  out_data_s;
    logic [15:0] rx_count;
    logic [3:0]  rx_count_s;
`ifdef STR_RX_PARITY_EN
    logic       par_bad;
    logic       in_par;
    logic       par_err, par_err_s;
    assign in_par = (^in_data) ^ par_bad;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    str_skid_receiver #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
`ifdef STR_RX_PARITY_EN
        .in_par(in_par), .par_err(par_err),
`endif
        .out_ready(out_ready), .in_ready(in_ready), .out_valid(out_valid),
        .out_data(out_data), .rx_count(rx_count)
    );

    str_skid_receiver #(.DATA_W(8), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
`ifdef STR_RX_PARITY_EN
        .in_par(in_par), .par_err(par_err_s),
`endif
        .out_ready(out_ready), .in_ready(in_ready_s), .out_valid(out_valid_s),
        .out_data(out_data_s), .rx_count(rx_count_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d);
        check({tag, " valid"}, 32'(out_valid), 32'(v));
        if (v) check({tag, " data"}, 32'(out_data), 32'(d));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
`ifdef STR_RX_PARITY_EN
        par_bad = 1'b0;
`endif
        // reset release
        tick(); tick(); tick();
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_data", 32'(out_data), 32'h00);
        check("rst rx_count", 32'(rx_count), 32'd0);
        rst = 1'b0;
        #1;
        check("post-rst in_ready", 32'(in_ready), 32'd1);

        // streaming with consumer always ready
        out_ready = 1'b1; in_valid = 1'b1;
        in_data = 8'h11; tick(); chk_out("stream0", 1'b1, 8'h11);
        check("stream0 in_ready", 32'(in_ready), 32'd1);
        in_data = 8'h22; tick(); chk_out("stream1", 1'b1, 8'h22);
        check("stream1 in_ready", 32'(in_ready), 32'd1);
        in_data = 8'h33; tick(); chk_out("stream2", 1'b1, 8'h33);
        check("stream2 in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0; tick(); chk_out("stream drain", 1'b0, 8'h00);
        check("stream rx_count", 32'(rx_count), 32'd3);

        // stall: two words fill the buffer, a third is held off
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'hA5; tick(); chk_out("stall0", 1'b1, 8'hA5);
        in_data = 8'h5A; tick(); chk_out("stall1", 1'b1, 8'hA5);
        check("stall full in_ready", 32'(in_ready), 32'd0);
        in_data = 8'hC3; tick(); chk_out("stall hold", 1'b1, 8'hA5);
        check("stall hold rx_count", 32'(rx_count), 32'd5);
        out_ready = 1'b1;
        tick(); chk_out("release0", 1'b1, 8'h5A);
        check("release in_ready", 32'(in_ready), 32'd1);
        tick(); chk_out("release1", 1'b1, 8'hC3);
        in_valid = 1'b0;
        tick(); chk_out("release drain", 1'b0, 8'h00);
        check("stall rx_count", 32'(rx_count), 32'd6);
        check("sat inst count 6", 32'(rx_count_s), 32'd6);

        // mid-operation reset with two words held
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'h77; tick();
        in_data = 8'h88; tick();
        check("midrst full", 32'(in_ready), 32'd0);
        in_valid = 1'b0; rst = 1'b1; tick();
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst out_data", 32'(out_data), 32'h00);
        check("midrst rx_count", 32'(rx_count), 32'd0);
        rst = 1'b0; out_ready = 1'b1;
        tick(); check("midrst after0", 32'(out_valid), 32'd0);
        tick(); check("midrst after1", 32'(out_valid), 32'd0);

        // saturation on the CNT_W=4 instance
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = 8'(i + 1);
            tick();
        end
        in_valid = 1'b0;
        check("sat last data", 32'(out_data), 32'd20);
        check("sat count 15", 32'(rx_count_s), 32'd15);
        check("wide count 20", 32'(rx_count), 32'd20);
        tick();
        check("sat count hold", 32'(rx_count_s), 32'd15);

`ifdef STR_RX_PARITY_EN
        check("par clear", 32'(par_err), 32'd0);
        in_valid = 1'b1; par_bad = 1'b1; in_data = 8'h03; tick();
        check("par err set", 32'(par_err), 32'd1);
        chk_out("par data", 1'b1, 8'h03);
        par_bad = 1'b0; in_data = 8'h01; tick();
        check("par err sticky", 32'(par_err), 32'd1);
        in_valid = 1'b0; tick();
        check("par err hold", 32'(par_err), 32'd1);
        rst = 1'b1; tick();
        check("par err rst", 32'(par_err), 32'd0);
        rst = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
